// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundle of the byte-stream handshake and IMEM write-port signals used by
// imem_loader.
//   slave  : the loader itself (consumes start/byte stream, drives IMEM writes
//            and status).
//   master : the stream source / system side (drives start and bytes, observes
//            IMEM writes and status).
// Signals:
//   start, byte_valid, byte_data[7:0]      stream source -> loader
//   byte_ready                              loader -> stream source
//   IMEM_wr_en, IMEM_wr_addr[ADDR_W-1:0],
//   IMEM_wr_data[31:0]                      loader -> IMEM write port
//   cpu_hold, done, error, words_written[6:0]  loader status
// -----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              IMEM_wr_en;
    logic [ADDR_W-1:0] IMEM_wr_addr;
    logic [31:0]       IMEM_wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [6:0]        words_written;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, IMEM_wr_en, IMEM_wr_addr, IMEM_wr_data,
        input  cpu_hold, done, error, words_written
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, IMEM_wr_en, IMEM_wr_addr, IMEM_wr_data,
        output cpu_hold, done, error, words_written
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads an instruction image into IMEM from a byte stream. The first byte of a
// load is the word count N; then 4*N bytes follow, assembled big-endian into
// 32-bit words and written to IMEM one word per write strobe, starting at
// BASE_ADDR and advancing by 4 (wrapping modulo 2^ADDR_W). The CPU is held in
// reset (cpu_hold) while a load is in progress or after a failed load.
//
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous active-high reset
//   bus    imem_loader_if.slave: start, byte_valid/byte_data/byte_ready stream,
//          IMEM_wr_en/IMEM_wr_addr/IMEM_wr_data write port,
//          cpu_hold, done, error, words_written status
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, every load (including N = 0) ends with one trailer byte that
//   must equal the XOR of all 4*N data bytes; a mismatch ends in the error
//   state. When undefined there is no trailer and no checksum logic.
//
// All outputs are registered: their next values are decoded from the next
// state so that they line up with the state register.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int unsigned       MAX_WORDS = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    imem_loader_if.slave bus
);
    localparam logic [7:0]        MAX_N    = 8'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(3'd4);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_BYTES = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , ST_CHK = 3'd6
`endif
    } state_t;

    // State reached once the image body is complete (also used for N = 0).
`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CHK;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;          // byte position within the word
    logic [23:0]       word_q, word_d;        // first three bytes of the word
    logic [7:0]        n_q, n_d;              // latched word count
    logic [ADDR_W-1:0] addr_q, addr_d;        // address of the next word
    logic [6:0]        ww_q, ww_d;            // words written this load
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              byte_ready_q, byte_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              xfer_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;

    // Running XOR checksum over the data bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        csum_next = acc ^ b;
    endfunction
`endif

    // Next-state and next-output computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        n_d       = n_q;
        addr_d    = addr_q;
        ww_d      = ww_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        // byte_ready_q already reflects the current state, so it qualifies the
        // transfer directly.
        xfer_s = bus.byte_valid && byte_ready_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    state_d = ST_COUNT;
                    ww_d    = 7'd0;
                    addr_d  = BASE_ADDR;
                    idx_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_COUNT: begin
                if (xfer_s) begin
                    if (bus.byte_data == 8'd0) begin
                        state_d = ST_TAIL;
                    end else if (bus.byte_data > MAX_N) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = bus.byte_data;
                        state_d = ST_BYTES;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_BYTES: begin
                if (xfer_s) begin
                    word_d = {word_q[15:0], bus.byte_data};
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_next(csum_q, bus.byte_data);
`endif
                    if (idx_q == 2'd3) begin
                        idx_d     = 2'd0;
                        state_d   = ST_WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {word_q, bus.byte_data};
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + WORD_INC;
                ww_d   = ww_q + 7'd1;
                if (({1'b0, ww_q} + 8'd1) == n_q) begin
                    state_d = ST_TAIL;
                end else begin
                    state_d = ST_BYTES;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer_s) begin
                    if (bus.byte_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs decoded from the state being entered.
        byte_ready_d = 1'b0;
        cpu_hold_d   = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        case (state_d)
            ST_COUNT, ST_BYTES: begin
                byte_ready_d = 1'b1;
                cpu_hold_d   = 1'b1;
            end
            ST_WRITE: begin
                cpu_hold_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            ST_ERR: begin
                error_d    = 1'b1;
                cpu_hold_d = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                byte_ready_d = 1'b1;
                cpu_hold_d   = 1'b1;
            end
`endif
            default: begin
                byte_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            word_q       <= 24'h000000;
            n_q          <= 8'd0;
            addr_q       <= BASE_ADDR;
            ww_q         <= 7'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= 32'h00000000;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            ww_q         <= ww_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            byte_ready_q <= byte_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.byte_ready    = byte_ready_q;
    assign bus.IMEM_wr_en    = wr_en_q;
    assign bus.IMEM_wr_addr  = wr_addr_q;
    assign bus.IMEM_wr_data  = wr_data_q;
    assign bus.cpu_hold      = cpu_hold_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.words_written = ww_q;
endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Two loaders (BASE_ADDR 0x00 and 0xFC) receive the same byte stream; every
// expected IMEM write is queued when a load is issued and a negedge monitor
// pops and compares each write strobe. Images are described as lists of
// 32-bit words; the expected byte order, addresses, trailer and final status
// are derived from those lists.
// -----------------------------------------------------------------------------
module tb_imem_loader;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif
    localparam int MAXW = 64;

    typedef struct {
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] words_q[$];
    exp_t        exp_q[$];
    exp_t        mon_e;

    imem_loader_if #(.ADDR_W(8)) bus0 ();
    imem_loader_if #(.ADDR_W(8)) bus1 ();

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00), .MAX_WORDS(MAXW)) dut0 (
        .CLK(clk), .RESET(rst), .bus(bus0)
    );
    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFC), .MAX_WORDS(MAXW)) dut1 (
        .CLK(clk), .RESET(rst), .bus(bus1)
    );

    assign bus1.start      = bus0.start;
    assign bus1.byte_valid = bus0.byte_valid;
    assign bus1.byte_data  = bus0.byte_data;

    always #5 clk = ~clk;

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus0.IMEM_wr_en || bus1.IMEM_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr0=%h addr1=%h data=%h, required no write",
                         bus0.IMEM_wr_addr, bus1.IMEM_wr_addr, bus0.IMEM_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (!(bus0.IMEM_wr_en && bus1.IMEM_wr_en &&
                      bus0.IMEM_wr_addr == mon_e.a0 && bus1.IMEM_wr_addr == mon_e.a1 &&
                      bus0.IMEM_wr_data == mon_e.d && bus1.IMEM_wr_data == mon_e.d &&
                      !bus0.byte_ready && !bus1.byte_ready)) begin
                    failures++;
                    $display("FAIL imem_write got en=%b%b addr0=%h addr1=%h data0=%h data1=%h rdy=%b%b, required en=11 addr0=%h addr1=%h data=%h rdy=00",
                             bus0.IMEM_wr_en, bus1.IMEM_wr_en, bus0.IMEM_wr_addr, bus1.IMEM_wr_addr,
                             bus0.IMEM_wr_data, bus1.IMEM_wr_data, bus0.byte_ready, bus1.byte_ready,
                             mon_e.a0, mon_e.a1, mon_e.d);
                end
            end
        end
    end

    function automatic int gap_for(input int mode, input int i);
        if (mode == 1) return i % 2;
        else if (mode == 2) return int'($urandom_range(0, 3));
        else return 0;
    endfunction

    // Present one byte (after an optional idle gap) and hold it until taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        bit acc;
        if (gap > 0) begin
            bus0.byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus0.byte_valid = 1'b1;
        bus0.byte_data  = b;
        bus0.start      = with_start;
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            if (bus0.byte_ready) acc = 1'b1;
            @(negedge clk);
            bus0.start = 1'b0;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL byte_accept got byte %h not taken within 64 cycles, required taken", b);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (bus0.byte_ready !== 1'b0 || bus0.IMEM_wr_en !== 1'b0 || bus0.cpu_hold !== 1'b0 ||
            bus0.done !== 1'b0 || bus0.error !== 1'b0 || bus0.words_written !== 7'd0 ||
            bus0.IMEM_wr_data !== 32'h0 || bus0.IMEM_wr_addr !== 8'h00 ||
            bus1.IMEM_wr_addr !== 8'hFC || bus1.cpu_hold !== 1'b0 || bus1.IMEM_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL %s got rdy=%b en=%b hold=%b done=%b err=%b ww=%0d data=%h addr0=%h addr1=%h, required all 0 addr0=00 addr1=fc",
                     tag, bus0.byte_ready, bus0.IMEM_wr_en, bus0.cpu_hold, bus0.done, bus0.error,
                     bus0.words_written, bus0.IMEM_wr_data, bus0.IMEM_wr_addr, bus1.IMEM_wr_addr);
        end
    endtask

    task automatic fill_words(input int n);
        words_q = {};
        for (int k = 0; k < n; k++) words_q.push_back($urandom);
    endtask

    // One complete load: header n, image words_q, trailer when checksums are on.
    task automatic run_load(input logic [7:0] n, input int gap_mode, input bit bad_trailer,
                            input bit mid_start);
        logic [7:0] x;
        logic [7:0] b;
        bit         hdr_err;
        bit         exp_err;
        logic [6:0] exp_ww;
        int         bi;
        exp_t       e;

        // Reference expectations.
        x       = 8'h00;
        hdr_err = (int'(n) > MAXW);
        exp_ww  = hdr_err ? 7'd0 : n[6:0];
        if (!hdr_err) begin
            for (int k = 0; k < int'(n); k++) begin
                e.a0 = 8'((4 * k) % 256);
                e.a1 = 8'((252 + 4 * k) % 256);
                e.d  = words_q[k];
                exp_q.push_back(e);
                x = x ^ words_q[k][31:24] ^ words_q[k][23:16] ^ words_q[k][15:8] ^ words_q[k][7:0];
            end
        end
        exp_err = hdr_err || (CSUM_ON && bad_trailer);

        // start together with a valid header byte: only start may act.
        bus0.start      = 1'b1;
        bus0.byte_valid = 1'b1;
        bus0.byte_data  = n;
        @(negedge clk);
        bus0.start = 1'b0;
        checks++;
        if (!(bus0.byte_ready === 1'b1 && bus0.cpu_hold === 1'b1 && bus0.done === 1'b0 &&
              bus0.error === 1'b0 && bus0.words_written === 7'd0)) begin
            failures++;
            $display("FAIL load_entry got rdy=%b hold=%b done=%b err=%b ww=%0d, required rdy=1 hold=1 done=0 err=0 ww=0",
                     bus0.byte_ready, bus0.cpu_hold, bus0.done, bus0.error, bus0.words_written);
        end

        send_byte(n, 0, 1'b0);
        bi = 0;
        if (!hdr_err) begin
            for (int k = 0; k < int'(n); k++) begin
                for (int j = 0; j < 4; j++) begin
                    b = words_q[k][31 - 8 * j -: 8];
                    send_byte(b, gap_for(gap_mode, bi),
                              mid_start && ($urandom_range(0, 7) == 0) && !(k == int'(n) - 1 && j == 3));
                    bi++;
                end
            end
            if (CSUM_ON) send_byte(x ^ {7'd0, bad_trailer}, gap_for(gap_mode, bi), 1'b0);
        end
        bus0.byte_valid = 1'b0;

        for (int t = 0; t < 100; t++) begin
            if (bus0.done || bus0.error) break;
            @(negedge clk);
        end
        checks++;
        if (!(bus0.done === !exp_err && bus0.error === exp_err && bus0.cpu_hold === exp_err &&
              bus0.words_written === exp_ww && bus0.byte_ready === 1'b0 &&
              bus1.done === !exp_err && bus1.error === exp_err && bus1.words_written === exp_ww)) begin
            failures++;
            $display("FAIL final_state n=%0d got done=%b err=%b hold=%b ww=%0d rdy=%b, required done=%b err=%b hold=%b ww=%0d rdy=0",
                     n, bus0.done, bus0.error, bus0.cpu_hold, bus0.words_written, bus0.byte_ready,
                     !exp_err, exp_err, exp_err, exp_ww);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL writes_missing got %0d expected writes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        bus0.start      = 1'b0;
        bus0.byte_valid = 1'b0;
        bus0.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset_state");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("idle_state");

        // Normal load.
        words_q = {32'h20080005, 32'h8C090004};
        run_load(8'd2, 0, 1'b0, 1'b0);

        // Backpressure: valid toggles mid-word, held across the WRITE cycle.
        run_load(8'd2, 1, 1'b0, 1'b0);

        // Illegal count, then recovery with an empty image.
        run_load(8'h41, 0, 1'b0, 1'b0);
        words_q = {};
        run_load(8'h00, 0, 1'b0, 1'b0);

        // Reset after two bytes of the first word.
        bus0.start      = 1'b1;
        bus0.byte_valid = 1'b1;
        bus0.byte_data  = 8'd2;
        @(negedge clk);
        bus0.start = 1'b0;
        send_byte(8'd2, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        bus0.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset_mid_load");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fresh load restarts at the base address.
        fill_words(3);
        run_load(8'd3, 0, 1'b0, 1'b0);

        // Checksum match and mismatch images (plain loads without the feature).
        words_q = {32'h11223344};
        run_load(8'd1, 0, 1'b0, 1'b0);
        run_load(8'd1, 0, 1'b1, 1'b0);

        // Maximum-size image.
        fill_words(MAXW);
        run_load(8'(MAXW), 2, 1'b0, 1'b1);

        // Randomized loads.
        for (int i = 0; i < 24; i++) begin
            int r;
            int n;
            r = int'($urandom_range(0, 9));
            if (r == 0) n = 0;
            else if (r == 1) n = int'($urandom_range(65, 255));
            else n = int'($urandom_range(1, 6));
            fill_words((n > MAXW) ? 0 : n);
            run_load(8'(n), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory fetch path: takes a byte stream over a valid/ready handshake, assembles 32-bit big-endian instruction words, and issues one-cycle write strobes into IMEM.
- Holds the processor in reset through cpu_hold while loading; cpu_hold is ORed into SYS_reset at top level.
- Sits beside PC/IMEM at system top. Its clock domain is the same as IMEM's write port.

Parameters:
- ADDR_W, 8, IMEM byte-address width; addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4.
- MAX_WORDS, 64, largest legal word count in the header.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte; a transfer occurs on an edge where byte_valid && byte_ready.
- IMEM_wr_en  out  1  one-cycle write strobe.
- IMEM_wr_addr  out  ADDR_W  word-aligned byte address.
- IMEM_wr_data  out  32  assembled instruction.
- cpu_hold  out  1  keeps the CPU in reset.
- done  out  1  load completed successfully.
- error  out  1  load aborted.
- words_written  out  7  words written in the current load.

Behaviour:
- Reset values: state = IDLE. All outputs are 0, and IMEM_wr_addr = BASE_ADDR. RESET overrides everything, including a load in progress; any partial word is discarded.
- IDLE:
  - byte_ready = 0, cpu_hold = 0.
  - start → COUNT. On entry: cpu_hold = 1, done = 0, error = 0, words_written = 0, address = BASE_ADDR, byte index = 0.
- COUNT:
  - byte_ready = 1. The first accepted byte is the word count N.
  - N = 0 → DONE.
  - N > MAX_WORDS → ERR.
  - Otherwise latch N → BYTES.
- BYTES:
  - byte_ready = 1. Each accepted byte shifts into the word register, MSB first: word = {word[23:0], byte}.
  - After the 4th byte → WRITE. The byte index resets to 0.
- WRITE (exactly 1 cycle):
  - byte_ready = 0, IMEM_wr_en = 1; IMEM_wr_addr and IMEM_wr_data are stable this cycle.
  - Next edge: address += 4 (wraps modulo 2^ADDR_W); words_written += 1.
  - If words_written + 1 == N → DONE (or CHK when the optional feature is enabled). Else → BYTES.
  - Effective throughput: at most one word per 5 cycles.
- DONE:
  - done = 1, cpu_hold = 0, byte_ready = 0.
  - Holds until start (→ COUNT, which clears done) or RESET.
- ERR:
  - error = 1, cpu_hold = 1 (the CPU must not run a partial image), byte_ready = 0.
  - Leaves only on start (→ COUNT) or RESET.
- Boundary and illegal conditions:
  - start asserted in COUNT, BYTES, WRITE or CHK is ignored.
  - byte_valid while byte_ready = 0 is not consumed; the sender must hold the byte.
  - byte_valid deasserted mid-word stalls indefinitely with no timeout; partial bytes are retained.
  - start and byte_valid in the same cycle in IDLE: only start acts, and the byte is not consumed.
  - IMEM_wr_addr and IMEM_wr_data keep their last values when IMEM_wr_en = 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE the FSM enters CHK with byte_ready = 1 and accepts one trailer byte.
  - The trailer must equal the XOR of all 4N data bytes.
  - Match → DONE. Mismatch → ERR. The already-written words remain in IMEM.
  - N = 0 still requires a trailer of 8'h00.
- Undefined: there is no CHK state or checksum register. The last WRITE goes directly to DONE, and no trailer is expected.

Test Plan:
- Normal load, macro off:
  - Stimulus: RESET, start, stream 02, 20 08 00 05, 8C 09 00 04.
  - Required: two IMEM_wr_en pulses — addr 0x00 data 0x20080005, then addr 0x04 data 0x8C090004.
  - Then done = 1, cpu_hold = 0, words_written = 2.
- Backpressure and stall:
  - Stimulus: byte_valid toggles every other cycle mid-word; hold byte_valid high across the WRITE cycle.
  - Required: identical data, no byte lost or duplicated, byte_ready = 0 exactly in the WRITE cycle.
- Illegal count:
  - Stimulus: header 0x41 with MAX_WORDS = 64.
  - Required: ERR, error = 1, cpu_hold = 1, no IMEM_wr_en pulses.
  - Then start with header 00 → done = 1, error = 0.
- Reset mid-load:
  - Stimulus: RESET asserted after 2 bytes of word 1.
  - Required: next cycle state IDLE, all outputs 0, no write issued.
  - A fresh load then writes from BASE_ADDR.
- Wrap-around:
  - Stimulus: BASE_ADDR = 0xFC, N = 2.
  - Required: writes land at 0xFC then 0x00.
- Checksum, LOADER_CHECKSUM_EN defined:
  - Stimulus: N = 1, data 11 22 33 44, trailer 0x44 → done = 1.
  - Repeat with trailer 0x45 → error = 1, cpu_hold = 1; the word still appears at 0x00.
